// File: rtl/bht_counter_table.sv
// Branch history table of 2-bit saturating counters, indexed by PC.
// The table is cleared by a one-entry-per-cycle sweep after reset or flush.
module bht_counter_table #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned VLEN       = 39
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            predict_valid_o,
  output logic            predict_taken_o,
  output logic            busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             predict_valid_q, predict_valid_d;
  logic             predict_taken_q, predict_taken_d;

  // Table storage has no reset; the sweep initialises every entry.
  logic             valid_q [NR_ENTRIES];
  logic [1:0]       ctr_q   [NR_ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             sweep_we;
  logic             update_en;
  logic             lookup_en;
  logic             upd_cur_valid;
  logic [1:0]       upd_cur_ctr;
  logic [1:0]       upd_new_ctr;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  logic             tbl_wvalid;
  logic [1:0]       tbl_wctr;

  // Bit 0 and the bits above the index do not select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                            update_pc_i[VLEN-1:IDX_W+1], update_pc_i[0]};

  assign lookup_idx = lookup_pc_i[IDX_W:1];
  assign update_idx = update_pc_i[IDX_W:1];

  // Next state and sweep write enable
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    sweep_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
        end
      end
      SWEEP: begin
        if (flush_i) begin
          sweep_idx_d = '0;
        end else begin
          sweep_we = 1'b1;
          if (sweep_idx_q == LAST_IDX) begin
            state_d     = IDLE;
            sweep_idx_d = '0;
          end else begin
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d     = SWEEP;
        sweep_idx_d = '0;
      end
    endcase
    if (rst_i) begin
      state_d     = SWEEP;
      sweep_idx_d = '0;
      sweep_we    = 1'b0;
    end
  end

  // Counter training
  always_comb begin
    update_en     = update_valid_i && (state_q == IDLE) && !flush_i &&
                    !debug_mode_i && !rst_i;
    upd_cur_valid = valid_q[update_idx];
    upd_cur_ctr   = ctr_q[update_idx];
    upd_new_ctr   = upd_cur_ctr;
    if (!upd_cur_valid) begin
      upd_new_ctr = update_taken_i ? 2'b10 : 2'b01;
    end else if (update_taken_i) begin
      if (upd_cur_ctr != 2'b11) upd_new_ctr = upd_cur_ctr + 2'b01;
    end else begin
      if (upd_cur_ctr != 2'b00) upd_new_ctr = upd_cur_ctr - 2'b01;
    end
  end

  // Single write port shared by sweep and update; they never coincide.
  always_comb begin
    tbl_we     = sweep_we || update_en;
    tbl_widx   = update_idx;
    tbl_wvalid = 1'b1;
    tbl_wctr   = upd_new_ctr;
    if (sweep_we) begin
      tbl_widx   = sweep_idx_q;
      tbl_wvalid = 1'b0;
      tbl_wctr   = 2'b01;
    end
  end

  // Lookup reads pre-write contents: no forwarding from a same-edge update.
  always_comb begin
    lookup_en       = lookup_valid_i && (state_q == IDLE) && !flush_i;
    predict_valid_d = lookup_en && valid_q[lookup_idx];
    predict_taken_d = predict_valid_d && ctr_q[lookup_idx][1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= SWEEP;
      sweep_idx_q     <= '0;
      predict_valid_q <= 1'b0;
      predict_taken_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_idx_q     <= sweep_idx_d;
      predict_valid_q <= predict_valid_d;
      predict_taken_q <= predict_taken_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      valid_q[tbl_widx] <= tbl_wvalid;
      ctr_q[tbl_widx]   <= tbl_wctr;
    end
  end

  assign predict_valid_o = predict_valid_q;
  assign predict_taken_o = predict_taken_q;
  assign busy_o          = (state_q == SWEEP);

endmodule

// File: tb/tb_bht_counter_table.sv
// Bench for bht_counter_table: directed scenarios plus random traffic,
// checked every cycle against a behavioural table model.
module tb_bht_counter_table;

  localparam int N    = 64;
  localparam int VLEN = 39;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            debug_mode_i = 1'b0;
  logic            lookup_valid_i = 1'b0;
  logic [VLEN-1:0] lookup_pc_i = '0;
  logic            update_valid_i = 1'b0;
  logic [VLEN-1:0] update_pc_i = '0;
  logic            update_taken_i = 1'b0;
  logic            predict_valid_o;
  logic            predict_taken_o;
  logic            busy_o;

  always #5 clk = ~clk;

  bht_counter_table #(.NR_ENTRIES(N), .VLEN(VLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .debug_mode_i   (debug_mode_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .update_valid_i (update_valid_i),
    .update_pc_i    (update_pc_i),
    .update_taken_i (update_taken_i),
    .predict_valid_o(predict_valid_o),
    .predict_taken_o(predict_taken_o),
    .busy_o         (busy_o)
  );

  // Behavioural model: per-entry valid flag and counter value 0..3,
  // plus "entries still to clear" while a sweep is running.
  bit m_valid [N];
  int m_ctr   [N];
  bit m_busy;
  int m_next_clear;
  bit exp_pv, exp_pt, model_on;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [VLEN-1:0] PC_A     = 39'h0080000010;
  localparam logic [VLEN-1:0] PC_ALIAS = 39'h0080000090;
  localparam logic [VLEN-1:0] PC_NEXT  = 39'h0080000012;

  function automatic int idx_of(input logic [VLEN-1:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  task automatic model_step(input bit r, f, d, lv, input logic [VLEN-1:0] lpc,
                            input bit uv, input logic [VLEN-1:0] upc, input bit ut);
    int li, ui;
    li = idx_of(lpc);
    ui = idx_of(upc);
    if (r) begin
      m_busy = 1; m_next_clear = 0; exp_pv = 0; exp_pt = 0;
      model_on = 1;
      return;
    end
    exp_pv = lv && !m_busy && !f && m_valid[li];
    exp_pt = exp_pv && (m_ctr[li] >= 2);
    if (m_busy) begin
      if (f) m_next_clear = 0;
      else begin
        m_valid[m_next_clear] = 0;
        m_ctr[m_next_clear] = 1;
        m_next_clear++;
        if (m_next_clear == N) begin m_busy = 0; m_next_clear = 0; end
      end
    end else if (f) begin
      m_busy = 1; m_next_clear = 0;
    end else if (uv && !d) begin
      if (!m_valid[ui]) begin
        m_valid[ui] = 1;
        m_ctr[ui] = ut ? 2 : 1;
      end else if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
      else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
    end
  endtask

  task automatic cycle(input bit r, f, d, lv, input logic [VLEN-1:0] lpc,
                       input bit uv, input logic [VLEN-1:0] upc, input bit ut);
    rst_i = r; flush_i = f; debug_mode_i = d;
    lookup_valid_i = lv; lookup_pc_i = lpc;
    update_valid_i = uv; update_pc_i = upc; update_taken_i = ut;
    @(posedge clk);
    model_step(r, f, d, lv, lpc, uv, upc, ut);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic lookup(input logic [VLEN-1:0] pc);
    cycle(0, 0, 0, 1, pc, 0, '0, 0);
  endtask

  task automatic update(input logic [VLEN-1:0] pc, input bit t);
    cycle(0, 0, 0, 0, '0, 1, pc, t);
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Counts busy cycles after the current edge; bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin idle(); n++; end
  endtask

  task automatic flush_and_wait();
    int n;
    cycle(0, 1, 0, 0, '0, 0, '0, 0);
    wait_sweep(n);
    check_lit("flush_sweep_len", n, N);
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      vectors++;
      if (predict_valid_o !== exp_pv || predict_taken_o !== exp_pt ||
          busy_o !== m_busy) begin
        miscompares++;
        $display("FAIL cycle_cmp: pv=%b pt=%b busy=%b expected pv=%b pt=%b busy=%b at %0t",
                 predict_valid_o, predict_taken_o, busy_o, exp_pv, exp_pt, m_busy, $time);
      end
    end
  end

  initial begin
    int n;
    int exp_seq [5];
    bit seq_t [5];
    logic [VLEN-1:0] rpc;
    exp_seq = '{2, 3, 3, 2, 1};
    seq_t   = '{1, 1, 1, 0, 0};
    model_on = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset sweep
    cycle(1, 0, 0, 0, '0, 0, '0, 0);
    check_lit("reset_busy", busy_o, 1);
    check_lit("reset_pv", predict_valid_o, 0);
    check_lit("reset_pt", predict_taken_o, 0);
    wait_sweep(n);
    check_lit("reset_sweep_len", n, 64);
    lookup(PC_A);
    check_lit("post_reset_pv", predict_valid_o, 0);

    // Training
    for (int i = 0; i < 5; i++) begin
      update(PC_A, seq_t[i]);
      check_lit("train_model_ctr", m_ctr[8], exp_seq[i]);
      lookup(PC_A);
      check_lit("train_pv", predict_valid_o, 1);
      check_lit("train_pt", predict_taken_o, (i < 4) ? 1 : 0);
    end

    // Aliasing
    flush_and_wait();
    update(PC_A, 1);
    update(PC_A, 1);
    lookup(PC_ALIAS);
    check_lit("alias_pv", predict_valid_o, 1);
    check_lit("alias_pt", predict_taken_o, 1);
    lookup(PC_NEXT);
    check_lit("neighbour_pv", predict_valid_o, 0);

    // Same-edge lookup and update
    flush_and_wait();
    update(PC_A, 0);
    cycle(0, 0, 0, 1, PC_A, 1, PC_A, 1);
    check_lit("hazard_pv", predict_valid_o, 1);
    check_lit("hazard_pt", predict_taken_o, 0);
    lookup(PC_A);
    check_lit("hazard_next_pt", predict_taken_o, 1);

    // Suppression
    flush_and_wait();
    cycle(0, 0, 1, 0, '0, 1, PC_A, 1);
    lookup(PC_A);
    check_lit("debug_drop_pv", predict_valid_o, 0);
    cycle(0, 1, 0, 0, '0, 1, PC_A, 1);
    wait_sweep(n);
    check_lit("flush_upd_sweep_len", n, 64);
    lookup(PC_A);
    check_lit("flush_drop_pv", predict_valid_o, 0);

    // Flush restart at sweep cycle 30, with traffic during the sweep
    update(PC_A, 1);
    cycle(0, 1, 0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 30; i++)
      cycle(0, 0, 0, 1, PC_A, 1, PC_A, 1);
    check_lit("mid_sweep_pv", predict_valid_o, 0);
    cycle(0, 1, 0, 1, PC_A, 1, PC_A, 1);
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      cycle(0, 0, 0, 1, PC_A, 1, PC_A, 1);
      n++;
    end
    check_lit("restart_sweep_len", n, 64);
    lookup(PC_A);
    check_lit("restart_pv", predict_valid_o, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, f, d, lv, uv, ut;
      logic [VLEN-1:0] lpc, upc;
      r  = ($urandom_range(0, 799) == 0);
      f  = ($urandom_range(0, 299) == 0);
      d  = ($urandom_range(0, 9) == 0);
      lv = $urandom_range(0, 1);
      uv = ($urandom_range(0, 2) != 0);
      ut = ($urandom_range(0, 3) != 0);
      rpc = VLEN'({$urandom(), $urandom()});
      rpc[6:1] = 6'($urandom_range(0, 11));
      lpc = rpc;
      rpc = VLEN'({$urandom(), $urandom()});
      rpc[6:1] = 6'($urandom_range(0, 11));
      upc = rpc;
      cycle(r, f, d, lv, lpc, uv, upc, ut);
    end
    idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bht_counter_table.md
BHT_COUNTER_TABLE -- requirements
Module: bht_counter_table

Interface
REQ-001 Parameter NR_ENTRIES, default 64, number of table entries; power of two, at least 4.
REQ-002 Parameter VLEN, default 39, virtual address width.
REQ-003 Port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port flush_i  in  1  request to clear the whole table.
REQ-006 Port debug_mode_i  in  1  core in debug mode; updates are suppressed.
REQ-007 Port lookup_valid_i  in  1  prediction request valid.
REQ-008 Port lookup_pc_i  in  VLEN  PC of the instruction to predict.
REQ-009 Port update_valid_i  in  1  resolved conditional branch (resolved valid and cf_type Branch).
REQ-010 Port update_pc_i  in  VLEN  PC of the resolved branch.
REQ-011 Port update_taken_i  in  1  resolved branch direction.
REQ-012 Port predict_valid_o  out  1  looked-up entry holds trained history.
REQ-013 Port predict_taken_o  out  1  predicted direction.
REQ-014 Port busy_o  out  1  clear sweep in progress.

Function
REQ-015 Each entry SHALL hold a 1-bit valid flag and a 2-bit saturating counter; predicted taken = counter[1].
REQ-016 The entry index SHALL be pc[log2(NR_ENTRIES):1]; pc bit 0 ignored; higher bits ignored (aliasing allowed).
REQ-017 The FSM SHALL have two states: IDLE and SWEEP.
- SWEEP: one entry per cycle, ascending from index 0, valid=0 and counter=2'b01.
- After index NR_ENTRIES-1 is written, return to IDLE.
REQ-018 IDLE -> SWEEP with sweep index 0 when flush_i=1 is sampled.
- flush_i=1 sampled during SWEEP restarts the sweep at index 0.
REQ-019 busy_o SHALL be 1 exactly while in SWEEP.
REQ-020 Lookup has 1-cycle latency.
- lookup_valid_i=1 sampled at edge t in IDLE: the outputs registered at t SHALL reflect the entry contents before any write at t.
- There is no same-cycle forwarding.
REQ-021 predict_valid_o SHALL be lookup accepted AND entry valid.
- predict_taken_o SHALL be counter[1] when predict_valid_o=1, else 0.
- If lookup_valid_i=0, or the FSM is in SWEEP or about to enter it, both outputs SHALL be 0 on the next cycle.
REQ-022 An update is applied at the sampling edge only if all hold:
- update_valid_i=1
- state IDLE
- flush_i=0
- debug_mode_i=0
Otherwise it is dropped, with no queuing.
REQ-023 Update to an invalid entry: set valid=1; counter = 2'b10 if taken, else 2'b01.
REQ-024 Update to a valid entry: counter +1 if taken, saturating at 2'b11; counter -1 if not taken, saturating at 2'b00.
REQ-025 Flush and update on the same edge: flush wins; the update is discarded.
REQ-026 Outputs SHALL be glitch-free registered signals; table state SHALL change only on clock edges.

Reset
REQ-027 rst_i=1 sampled SHALL force the following at that edge:
- SWEEP with index 0
- predict_valid_o=0, predict_taken_o=0, busy_o=1
REQ-028 The table array itself SHALL NOT require reset; the post-reset sweep initialises it in NR_ENTRIES cycles.
REQ-029 rst_i asserted mid-sweep or mid-operation SHALL restart the sweep at index 0; pending lookups are discarded.
REQ-030 rst_i has priority over flush_i, update and lookup.

Verification
REQ-031 Reset sweep: rst_i high for 1 cycle.
- busy_o=1 for exactly 64 cycles, then 0.
- Afterwards, a lookup of PC 0x80000010 returns predict_valid_o=0.
REQ-032 Training: updates at PC 0x80000010, in order taken, taken, taken, not-taken.
- Counter sequence 10, 11, 11, 10.
- Lookup after each update returns valid=1 and taken=1.
- A further not-taken gives counter 01 and taken=0.
REQ-033 Aliasing: train 0x80000010 taken twice, then look up 0x80000090 (same index 8).
- Returns valid=1, taken=1.
- A lookup of 0x80000012 (index 9) returns valid=0.
REQ-034 Same-edge hazard: entry at index 8 is 01; lookup and taken-update of index 8 on the same edge.
- Output taken=0.
- The next lookup returns taken=1 (counter 10).
REQ-035 Suppression: with debug_mode_i=1, a taken update at 0x80000010 is dropped.
- Entry stays invalid; lookup returns valid=0.
- An update issued together with flush_i=1 is likewise dropped.
REQ-036 Flush restart: flush_i pulsed at sweep cycle 30, after index 29 is cleared.
- busy_o stays 1 for 64 further cycles.
- Updates and lookups during the sweep have no effect; lookup outputs are 0.
